// File: rtl/led_sweep_if.sv
// Host controls and LED/buzzer status for led_sweep_ctrl; master drives
// start_stop/mode, slave (the controller) drives the display outputs.
interface led_sweep_if #(
  parameter int N_LED = 5
) ();
  logic                       start_stop;
  logic [1:0]                 mode;
  logic [N_LED-1:0]           led;
  logic [$clog2(N_LED)-1:0]   pos;
  logic                       busy;
  logic                       sweep_done;
  logic                       buzz;

  modport master (
    output start_stop, mode,
    input  led, pos, busy, sweep_done, buzz
  );

  modport slave (
    input  start_stop, mode,
    output led, pos, busy, sweep_done, buzz
  );
endinterface

// File: rtl/led_sweep_ctrl.sv
// One-hot running light (hold/up/down/bounce) with internal step prescaler; outputs are registered, one cycle after cause.
// No backpressure: start_stop pauses in place. Buzzer on sweep_done only when LED_SWEEP_BUZZER_EN is defined.
module led_sweep_ctrl #(
  parameter int N_LED      = 5,
  parameter int TICK_DIV   = 47000000,
  parameter int BUZZ_HALF  = 25000,
  parameter int BEEP_TICKS = 1
) (
  input  logic       clk_in,
  input  logic       reset,
  led_sweep_if.slave bus
);

  localparam int POS_W   = $clog2(N_LED);
  localparam int PRESC_W = $clog2(TICK_DIV);

  localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(N_LED - 1);
  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_UP   = 2'd1;
  localparam logic [1:0] MODE_DOWN = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PARK = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               dir_q, dir_d;
  logic [N_LED-1:0]   led_q, led_d;
  logic [1:0]         last_mode_q;
  logic               busy_q;
  logic               done_q, done_d;

  logic               tick;
  logic               mode_chg;
  logic [POS_W-1:0]   start_pos;
  logic               start_dir;

  // dir = 0 moves toward MSB, dir = 1 toward LSB.
  assign tick      = (state_q == RUN) && bus.start_stop && (presc_q == TICK_LAST);
  assign mode_chg  = (bus.mode != last_mode_q);
  assign start_pos = (bus.mode == MODE_DOWN) ? POS_LAST : '0;
  assign start_dir = (bus.mode == MODE_DOWN);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    led_d   = '0;

    case (state_q)
      IDLE: begin
        if (bus.start_stop && (bus.mode != MODE_HOLD)) begin
          state_d = RUN;
          presc_d = '0;
          pos_d   = start_pos;
          dir_d   = start_dir;
        end
      end

      RUN: begin
        // Mode change outranks a coincident tick; a pause freezes everything.
        if (bus.mode == MODE_HOLD) begin
          state_d = PARK;
        end else if (mode_chg) begin
          presc_d = '0;
          pos_d   = start_pos;
          dir_d   = start_dir;
        end else if (bus.start_stop) begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            case (bus.mode)
              MODE_UP: begin
                if (pos_q == POS_LAST) begin
                  done_d  = 1'b1;
                  state_d = PARK;
                end else begin
                  pos_d = pos_q + 1'b1;
                end
              end
              MODE_DOWN: begin
                if (pos_q == '0) begin
                  done_d  = 1'b1;
                  state_d = PARK;
                end else begin
                  pos_d = pos_q - 1'b1;
                end
              end
              default: begin
                pos_d = dir_q ? pos_q - 1'b1 : pos_q + 1'b1;
                if ((pos_d == '0) || (pos_d == POS_LAST)) begin
                  dir_d  = ~dir_q;
                  done_d = 1'b1;
                end
              end
            endcase
          end
        end
      end

      PARK: begin
        // A finished sweep only restarts on a genuinely new mode.
        if (bus.start_stop && (bus.mode != MODE_HOLD) && mode_chg) begin
          state_d = RUN;
          presc_d = '0;
          pos_d   = start_pos;
          dir_d   = start_dir;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != IDLE) begin
      led_d = N_LED'(1) << pos_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      led_q       <= '0;
      last_mode_q <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      led_q       <= led_d;
      last_mode_q <= bus.mode;
      busy_q      <= (state_d == RUN);
      done_q      <= done_d;
    end
  end

  assign bus.led        = led_q;
  assign bus.pos        = pos_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = done_q;

`ifdef LED_SWEEP_BUZZER_EN
  localparam int HALF_W = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
  localparam int BEEP_W = (BEEP_TICKS > 0) ? $clog2(BEEP_TICKS + 1) : 1;

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(BUZZ_HALF - 1);

  logic [PRESC_W-1:0] beep_div_q;
  logic [HALF_W-1:0]  half_q;
  logic [BEEP_W-1:0]  beep_left_q;
  logic               buzz_q;

  // Own divider so the beep length holds even while the step prescaler is frozen.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      beep_div_q  <= '0;
      half_q      <= '0;
      beep_left_q <= '0;
      buzz_q      <= 1'b0;
    end else if (done_d) begin
      beep_div_q  <= '0;
      half_q      <= '0;
      beep_left_q <= BEEP_W'(BEEP_TICKS);
      buzz_q      <= 1'b1;
    end else if (beep_left_q != '0) begin
      if (half_q == HALF_LAST) begin
        half_q <= '0;
        buzz_q <= ~buzz_q;
      end else begin
        half_q <= half_q + 1'b1;
      end
      if (beep_div_q == TICK_LAST) begin
        beep_div_q  <= '0;
        beep_left_q <= beep_left_q - 1'b1;
        if (beep_left_q == BEEP_W'(1)) begin
          half_q <= '0;
          buzz_q <= 1'b0;
        end
      end else begin
        beep_div_q <= beep_div_q + 1'b1;
      end
    end
  end

  assign bus.buzz = buzz_q;
`else
  assign bus.buzz = 1'b0;
`endif

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Directed, table-driven bench for led_sweep_ctrl with N_LED=5, TICK_DIV=4, BUZZ_HALF=2, BEEP_TICKS=1.
module tb_led_sweep_ctrl;

  logic clk_in;
  logic reset;

  led_sweep_if #(.N_LED(5)) bus ();

  led_sweep_ctrl #(
    .N_LED     (5),
    .TICK_DIV  (4),
    .BUZZ_HALF (2),
    .BEEP_TICKS(1)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       start_stop;
    logic [1:0] mode;
    int         wait_cyc;
    logic [4:0] led;
    logic [2:0] pos;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ss, input logic [1:0] md, input int w,
                              input logic [4:0] l, input logic [2:0] p,
                              input logic b, input logic d);
    vec_t v;
    v.start_stop = ss;
    v.mode       = md;
    v.wait_cyc   = w;
    v.led        = l;
    v.pos        = p;
    v.busy       = b;
    v.done       = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] l, input logic [2:0] p,
                         input logic b, input logic d);
    chk({tag, "_led"},  32'(bus.led),        32'(l));
    chk({tag, "_pos"},  32'(bus.pos),        32'(p));
    chk({tag, "_busy"}, 32'(bus.busy),       32'(b));
    chk({tag, "_done"}, 32'(bus.sweep_done), 32'(d));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  logic [5:0] buzz_exp;

  initial begin
    // Mode 1 sweep, no restart on same mode, then mode 2 sweep, then bounce.
    vecs.push_back(mk(1'b1, 2'd1,  1, 5'b00001, 3'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd1,  3, 5'b00001, 3'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd1,  1, 5'b00010, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd1,  4, 5'b00100, 3'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd1,  4, 5'b01000, 3'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd1,  4, 5'b10000, 3'd4, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd1,  3, 5'b10000, 3'd4, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd1,  1, 5'b10000, 3'd4, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'd1,  1, 5'b10000, 3'd4, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'd1, 10, 5'b10000, 3'd4, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'd2,  1, 5'b10000, 3'd4, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd2,  4, 5'b01000, 3'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd2,  4, 5'b00100, 3'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd2,  4, 5'b00010, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd2,  4, 5'b00001, 3'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd2,  4, 5'b00001, 3'd0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'd2,  1, 5'b00001, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'd2,  6, 5'b00001, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'd3,  1, 5'b00001, 3'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd3,  4, 5'b00010, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd3,  4, 5'b00100, 3'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd3,  4, 5'b01000, 3'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd3,  4, 5'b10000, 3'd4, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 2'd3,  4, 5'b01000, 3'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd3,  4, 5'b00100, 3'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd3,  4, 5'b00010, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd3,  4, 5'b00001, 3'd0, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 2'd3,  4, 5'b00010, 3'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd3,  4, 5'b00100, 3'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 2'd3,  4, 5'b01000, 3'd3, 1'b1, 1'b0));

`ifdef LED_SWEEP_BUZZER_EN
    buzz_exp = 6'b000011;
`else
    buzz_exp = 6'b000000;
`endif

    // Reset state
    reset          = 1'b0;
    bus.start_stop = 1'b0;
    bus.mode       = 2'd0;
    cyc(3);
    reset = 1'b1;
    chk_out("reset", 5'b00000, 3'd0, 1'b0, 1'b0);
    chk("reset_buzz", 32'(bus.buzz), 32'd0);
    bus.start_stop = 1'b1;
    cyc(2);
    chk_out("idle_hold", 5'b00000, 3'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      bus.start_stop = vecs[i].start_stop;
      bus.mode       = vecs[i].mode;
      cyc(vecs[i].wait_cyc);
      chk_out($sformatf("vec%0d", i), vecs[i].led, vecs[i].pos, vecs[i].busy, vecs[i].done);
`ifndef LED_SWEEP_BUZZER_EN
      chk($sformatf("vec%0d_buzz", i), 32'(bus.buzz), 32'd0);
`endif
    end

    // Pause at pos 2 with prescaler at 2: step resumes exactly 2 cycles later.
    bus.mode = 2'd1;
    cyc(9);
    chk_out("pause_pre", 5'b00100, 3'd2, 1'b1, 1'b0);
    cyc(2);
    bus.start_stop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk($sformatf("pause_led%0d", i), 32'(bus.led), 32'(5'b00100));
      chk($sformatf("pause_busy%0d", i), 32'(bus.busy), 32'd1);
    end
    bus.start_stop = 1'b1;
    cyc(1);
    chk_out("resume_1", 5'b00100, 3'd2, 1'b1, 1'b0);
    cyc(1);
    chk_out("resume_2", 5'b01000, 3'd3, 1'b1, 1'b0);

    // Mode 0 while running parks in place without a strobe.
    bus.mode = 2'd0;
    cyc(1);
    chk_out("park_mode0", 5'b01000, 3'd3, 1'b0, 1'b0);
    cyc(3);
    chk_out("park_hold", 5'b01000, 3'd3, 1'b0, 1'b0);

    // Mode change landing on a tick cycle restarts with no step and no strobe.
    bus.mode = 2'd1;
    cyc(4);
    chk_out("chg_pre", 5'b00001, 3'd0, 1'b1, 1'b0);
    bus.mode = 2'd2;
    cyc(1);
    chk_out("chg_tick", 5'b10000, 3'd4, 1'b1, 1'b0);
    cyc(3);
    chk_out("chg_hold", 5'b10000, 3'd4, 1'b1, 1'b0);
    cyc(1);
    chk_out("chg_step", 5'b01000, 3'd3, 1'b1, 1'b0);

    // Buzzer after a mode-1 sweep.
    bus.mode = 2'd0;
    cyc(1);
    bus.mode = 2'd1;
    cyc(20);
    chk("buzz_pre_done", 32'(bus.sweep_done), 32'd0);
    chk("buzz_pre", 32'(bus.buzz), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk($sformatf("buzz_seq%0d", i), 32'(bus.buzz), 32'(buzz_exp[i]));
    end

    // Reset mid-beep clears everything on the next cycle.
    bus.mode = 2'd0;
    cyc(1);
    bus.mode = 2'd1;
    cyc(22);
    chk("midbeep_buzz", 32'(bus.buzz), 32'(buzz_exp[1]));
    reset = 1'b0;
    cyc(1);
    chk_out("midbeep_rst", 5'b00000, 3'd0, 1'b0, 1'b0);
    chk("midbeep_rst_buzz", 32'(bus.buzz), 32'd0);
    reset    = 1'b1;
    bus.mode = 2'd0;
    cyc(2);
    chk_out("post_rst", 5'b00000, 3'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
